// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared FSM state type, sizing helper and reference truth tables for the gate sweep sequencer
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int N_IN_DEF = 2;
    localparam int N_VEC    = 2 ** N_IN_DEF;

    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if: start/gate handshake and result bus of the gate sweep sequencer
// Signals: start, dut_y (toward the sequencer); vec_o, busy, done, pass, err_cnt,
//          first_err_vec, err_valid (from the sequencer).
// Modports: master = sequencer side, slave = start logic / gate-under-test side.
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            dut_y;
    logic [N_IN-1:0] vec_o;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;
    logic            err_valid;

    modport master (
        input  start, dut_y,
        output vec_o, busy, done, pass, err_cnt, first_err_vec, err_valid
    );

    modport slave (
        output start, dut_y,
        input  vec_o, busy, done, pass, err_cnt, first_err_vec, err_valid
    );

endinterface

// File: rtl/sweep_settle_cnt.sv
// sweep_settle_cnt: loadable down-counter with a zero flag, times the settle wait of each vector
// Ports: clk, rst_n (async active-low); load_i loads val_i (has priority);
//        dec_i counts down and holds at zero; zero_o is high while the count is zero.
module sweep_settle_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives every input vector of a small gate in ascending order, samples its output after a settle wait and checks it against a truth table
// Ports: clk; rst_n (async active-low); bus (gate_sweep_ctrl_if.master):
//   start (level, sampled in IDLE/DONE), dut_y (gate output) in;
//   vec_o (vector to gate), busy, done, pass, err_cnt (saturating), first_err_vec, err_valid out.
// Build option: define GATE_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module gate_sweep_ctrl #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b1110
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_sweep_ctrl_if.master bus
);
    import gate_sweep_pkg::*;

    localparam int              NV          = n_vec(N_IN);
    localparam int              CW          = SETTLE > 2 ? $clog2(SETTLE) : 1;
    localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(NV);
    localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(NV - 1);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] first_q, first_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic            err_valid_q, err_valid_d;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            mismatch, last_vec, done_w;

    sweep_settle_cnt #(.W(CW)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .val_i  (SETTLE_LOAD),
        .zero_o (cnt_zero)
    );

    // Case inequality so an X/Z gate output in simulation counts as a failure.
    assign mismatch = bus.dut_y !== EXPECT[vec_q];
    assign last_vec = vec_q == VEC_LAST;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        first_d     = first_q;
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    first_d     = '0;
                    err_cnt_d   = '0;
                    err_valid_d = 1'b0;
                end
            end
            DRIVE: begin
                cnt_load = 1'b1;
                state_d  = gate_sweep_pkg::SETTLE;
            end
            gate_sweep_pkg::SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
                    if (!err_valid_q) begin
                        first_d     = vec_q;
                        err_valid_d = 1'b1;
                    end
                end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            first_q     <= '0;
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            first_q     <= first_d;
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign done_w            = state_q == DONE;
    assign bus.vec_o         = vec_q;
    assign bus.busy          = state_q == DRIVE || state_q == gate_sweep_pkg::SETTLE || state_q == SAMPLE;
    assign bus.done          = done_w;
    assign bus.pass          = done_w && err_cnt_q == '0;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_vec = first_q;
    assign bus.err_valid     = err_valid_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: self-checking bench for gate_sweep_ctrl (OR2 default instance and OR3/SETTLE=1 instance)
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

`ifdef GATE_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int TT_A = int'(TT_OR2);
    localparam int TT_B = 'hFE;

    typedef struct {
        int vec;
        int busy;
        int done;
        int pass;
        int err_cnt;
        int first;
        int err_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mode_a = 0;
    int   run_a = 0;
    int   k_a = 0;
    int   k_b = 0;

    gate_sweep_ctrl_if #(.N_IN(2)) bus_a ();
    gate_sweep_ctrl_if #(.N_IN(3)) bus_b ();

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .EXPECT(TT_OR2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXPECT(8'b1111_1110)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Gate models: 0 = OR, 1 = AND, 2 = stuck-at-0.
    function automatic bit gate(input int mode, input int nin, input int v);
        return mode == 0 ? v != 0 : mode == 1 ? v == (1 << nin) - 1 : 1'b0;
    endfunction

    function automatic bit bad(input int nin, input int tt, input int mode, input int v);
        return gate(mode, nin, v) != tt[v];
    endfunction

    function automatic int last_vec(input int nin, input int tt, input int mode);
        if (STOP) for (int v = 0; v < (1 << nin); v++) if (bad(nin, tt, mode, v)) return v;
        return (1 << nin) - 1;
    endfunction

    // Cycle (counted from the start edge) on which done first shows.
    function automatic int done_k(input int nin, input int st, input int tt, input int mode);
        return (last_vec(nin, tt, mode) + 1) * (st + 2) + 1;
    endfunction

    // Expected outputs k cycles after start was taken; k = 0 means nothing since reset.
    function automatic exp_t model(input int nin, input int st, input int tt, input int mode, input int k);
        exp_t e;
        int   p;
        int   lv;
        int   dk;
        e  = '{default: 0};
        p  = st + 2;
        lv = last_vec(nin, tt, mode);
        dk = (lv + 1) * p + 1;
        if (k == 0) return e;
        e.done = k >= dk ? 1 : 0;
        e.busy = k >= dk ? 0 : 1;
        e.vec  = k >= dk ? lv : (k - 1) / p;
        for (int u = 0; u <= lv; u++) begin
            if ((u + 1) * p + 1 <= k && bad(nin, tt, mode, u)) begin
                if (e.err_cnt == 0) begin
                    e.first     = u;
                    e.err_valid = 1;
                end
                e.err_cnt++;
            end
        end
        e.pass = (e.done == 1 && e.err_cnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    assign bus_a.dut_y = gate(mode_a, 2, int'(bus_a.vec_o));
    assign bus_b.dut_y = gate(2, 3, int'(bus_b.vec_o));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_a <= 0;
            k_b <= 0;
        end else begin
            if ((k_a == 0 || k_a >= done_k(2, 2, TT_A, run_a)) && bus_a.start == 1'b1) begin
                k_a   <= 1;
                run_a <= mode_a;
            end else if (k_a > 0 && k_a < done_k(2, 2, TT_A, run_a)) begin
                k_a <= k_a + 1;
            end
            if ((k_b == 0 || k_b >= done_k(3, 1, TT_B, 2)) && bus_b.start == 1'b1) k_b <= 1;
            else if (k_b > 0 && k_b < done_k(3, 1, TT_B, 2)) k_b <= k_b + 1;
        end
    end

    always @(negedge clk) begin : cmp
        exp_t ea;
        exp_t eb;
        ea = model(2, 2, TT_A, run_a, k_a);
        eb = model(3, 1, TT_B, 2, k_b);
        chk("a_vec", 32'(bus_a.vec_o), ea.vec);
        chk("a_busy", 32'(bus_a.busy), ea.busy);
        chk("a_done", 32'(bus_a.done), ea.done);
        chk("a_err_cnt", 32'(bus_a.err_cnt), ea.err_cnt);
        chk("a_first_err_vec", 32'(bus_a.first_err_vec), ea.first);
        chk("a_err_valid", 32'(bus_a.err_valid), ea.err_valid);
        if (ea.done == 1) chk("a_pass", 32'(bus_a.pass), ea.pass);
        chk("b_vec", 32'(bus_b.vec_o), eb.vec);
        chk("b_busy", 32'(bus_b.busy), eb.busy);
        chk("b_done", 32'(bus_b.done), eb.done);
        chk("b_err_cnt", 32'(bus_b.err_cnt), eb.err_cnt);
        chk("b_first_err_vec", 32'(bus_b.first_err_vec), eb.first);
        chk("b_err_valid", 32'(bus_b.err_valid), eb.err_valid);
        if (eb.done == 1) chk("b_pass", 32'(bus_b.pass), eb.pass);
    end

    // Call on a falling edge; returns the count of falling edges until done is seen.
    task automatic sweep(input bit sel, output int cyc);
        cyc = 0;
        if (sel) bus_b.start = 1'b1;
        else     bus_a.start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            bus_a.start = 1'b0;
            bus_b.start = 1'b0;
        end while ((sel ? bus_b.done : bus_a.done) != 1'b1 && cyc < 300);
        if ((sel ? bus_b.done : bus_a.done) != 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep_timeout: done=0 after %0d cycles, required done=1", cyc);
        end
    endtask

    initial begin
        int cyc;
        int dcnt;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", 32'(bus_a.vec_o), 0);
        chk("rst_busy", 32'(bus_a.busy), 0);
        chk("rst_done", 32'(bus_a.done), 0);
        chk("rst_pass", 32'(bus_a.pass), 0);
        rst_n = 1'b1;
        @(negedge clk);

        mode_a = 0;
        sweep(1'b0, cyc);
        chk("or2_len", cyc - 1, 16);
        chk("or2_pass", 32'(bus_a.pass), 1);
        chk("or2_err_cnt", 32'(bus_a.err_cnt), 0);
        chk("or2_err_valid", 32'(bus_a.err_valid), 0);
        chk("or2_vec", 32'(bus_a.vec_o), 3);

        mode_a = 1;
        sweep(1'b0, cyc);
        chk("and2_len", cyc - 1, STOP ? 8 : 16);
        chk("and2_err_cnt", 32'(bus_a.err_cnt), STOP ? 1 : 2);
        chk("and2_first", 32'(bus_a.first_err_vec), 1);
        chk("and2_err_valid", 32'(bus_a.err_valid), 1);
        chk("and2_pass", 32'(bus_a.pass), 0);
        chk("and2_vec", 32'(bus_a.vec_o), STOP ? 1 : 3);

        mode_a = STOP ? 0 : 1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_vec", 32'(bus_a.vec_o), 2);
        chk("pre_rst_err_cnt", 32'(bus_a.err_cnt), STOP ? 0 : 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", 32'(bus_a.vec_o), 0);
        chk("mid_rst_busy", 32'(bus_a.busy), 0);
        chk("mid_rst_err_cnt", 32'(bus_a.err_cnt), 0);
        chk("mid_rst_err_valid", 32'(bus_a.err_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode_a = 0;
        sweep(1'b0, cyc);
        chk("post_rst_len", cyc - 1, 16);
        chk("post_rst_pass", 32'(bus_a.pass), 1);

        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 1;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        bus_a.start = 1'b1;
        @(negedge clk);
        cyc++;
        bus_a.start = 1'b0;
        while (!bus_a.done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("midstart_len", cyc - 1, 16);
        dcnt = 0;
        bus_a.start = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (bus_a.done) dcnt++;
        end
        bus_a.start = 1'b0;
        chk("held_done_pulses", dcnt, 2);
        chk("held_done_end", 32'(bus_a.done), 1);
        chk("held_pass", 32'(bus_a.pass), 1);

        sweep(1'b1, cyc);
        chk("or3_len", cyc - 1, STOP ? 6 : 24);
        chk("or3_err_cnt", 32'(bus_b.err_cnt), STOP ? 1 : 7);
        chk("or3_first", 32'(bus_b.first_err_vec), 1);
        chk("or3_vec", 32'(bus_b.vec_o), STOP ? 1 : 7);
        chk("or3_pass", 32'(bus_b.pass), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
